riscv_wb: RTL and testbench

//   Writeback stage and integer register file. Sits directly downstream of the MEM stage.

---
 rtl/riscv_wb.sv | 94 +++++++++
 tb/tb_riscv_wb.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_wb.sv
// Writeback stage and integer register file: commits MEM->WB transfers, serves two read ports.
// Define RISCV_WB_BYPASS_EN to forward the committing write to same-cycle reads.
module riscv_wb #(
  parameter int XLEN      = 32,
  parameter int INSTRET_W = 64
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 mem_wb_rdy,
  output logic                 mem_wb_ack,
  input  logic [XLEN-1:0]      mem_wb_data,
  input  logic [4:0]           mem_wb_rd,
  input  logic                 mem_wb_we,
  input  logic                 wb_stall,
  input  logic [4:0]           rs1_addr,
  output logic [XLEN-1:0]      rs1_data,
  input  logic [4:0]           rs2_addr,
  output logic [XLEN-1:0]      rs2_data,
  output logic                 wb_valid,
  output logic [4:0]           wb_rd,
  output logic [XLEN-1:0]      wb_data,
  output logic [INSTRET_W-1:0] instret
);

  logic [XLEN-1:0]      regs_q [32];
  logic                 commit;
  logic                 wr_en;
  logic                 wb_valid_q, wb_valid_d;
  logic [4:0]           wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]      wb_data_q, wb_data_d;
  logic [INSTRET_W-1:0] instret_q, instret_d;

  assign mem_wb_ack = !wb_stall;
  assign commit     = mem_wb_rdy && mem_wb_ack;
  assign wr_en      = commit && mem_wb_we && (mem_wb_rd != 5'd0);

  // Entry 0 is never written; reads of x0 are also forced to zero below.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[mem_wb_rd] <= mem_wb_data;
    end
  end

  always_comb begin
    rs1_data = regs_q[rs1_addr];
`ifdef RISCV_WB_BYPASS_EN
    if (wr_en && (rs1_addr == mem_wb_rd)) rs1_data = mem_wb_data;
`endif
    if (rs1_addr == 5'd0) rs1_data = '0;
  end

  always_comb begin
    rs2_data = regs_q[rs2_addr];
`ifdef RISCV_WB_BYPASS_EN
    if (wr_en && (rs2_addr == mem_wb_rd)) rs2_data = mem_wb_data;
`endif
    if (rs2_addr == 5'd0) rs2_data = '0;
  end

  // wb_rd/wb_data hold between commits; wb_valid is a one-cycle pulse.
  always_comb begin
    wb_valid_d = commit;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    instret_d  = instret_q;
    if (commit) begin
      wb_rd_d   = mem_wb_we ? mem_wb_rd : 5'd0;
      wb_data_d = mem_wb_data;
      instret_d = instret_q + {{(INSTRET_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wb_valid_q <= 1'b0;
      wb_rd_q    <= 5'd0;
      wb_data_q  <= '0;
      instret_q  <= '0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      instret_q  <= instret_d;
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_rd    = wb_rd_q;
  assign wb_data  = wb_data_q;
  assign instret  = instret_q;

endmodule

// File: tb/tb_riscv_wb.sv
// Bench for riscv_wb: directed scenarios plus randomized traffic against an array-based model.
// A second instance with a 4-bit retire counter exercises counter wrap-around.
module tb_riscv_wb;

  logic        clk;
  logic        rstn;
  logic        mem_wb_rdy;
  logic        mem_wb_ack, ack_s;
  logic [31:0] mem_wb_data;
  logic [4:0]  mem_wb_rd;
  logic        mem_wb_we;
  logic        wb_stall;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data, rs1_s, rs2_s;
  logic        wb_valid, valid_s;
  logic [4:0]  wb_rd, wb_rd_s;
  logic [31:0] wb_data, wb_data_s;
  logic [63:0] instret;
  logic [3:0]  instret_s;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef RISCV_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  // Reference state: architectural view of the register file and status outputs.
  logic [31:0] m_regs [32];
  logic        m_valid;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  logic [63:0] m_instret;

  riscv_wb #(.XLEN(32), .INSTRET_W(64)) dut (
    .clk(clk), .rstn(rstn), .mem_wb_rdy(mem_wb_rdy), .mem_wb_ack(mem_wb_ack),
    .mem_wb_data(mem_wb_data), .mem_wb_rd(mem_wb_rd), .mem_wb_we(mem_wb_we),
    .wb_stall(wb_stall), .rs1_addr(rs1_addr), .rs1_data(rs1_data),
    .rs2_addr(rs2_addr), .rs2_data(rs2_data), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_data(wb_data), .instret(instret)
  );

  riscv_wb #(.XLEN(32), .INSTRET_W(4)) dut_s (
    .clk(clk), .rstn(rstn), .mem_wb_rdy(mem_wb_rdy), .mem_wb_ack(ack_s),
    .mem_wb_data(mem_wb_data), .mem_wb_rd(mem_wb_rd), .mem_wb_we(mem_wb_we),
    .wb_stall(wb_stall), .rs1_addr(rs1_addr), .rs1_data(rs1_s),
    .rs2_addr(rs2_addr), .rs2_data(rs2_s), .wb_valid(valid_s),
    .wb_rd(wb_rd_s), .wb_data(wb_data_s), .instret(instret_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (BYPASS && rstn && mem_wb_rdy && !wb_stall && mem_wb_we && mem_wb_rd == a)
      return mem_wb_data;
    return m_regs[a];
  endfunction

  // Per-cycle comparison at the falling edge, model update at the rising edge.
  initial begin
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_valid = 1'b0; m_rd = 5'd0; m_data = 32'd0; m_instret = 64'd0;
    forever begin
      @(negedge clk);
      if (rstn) begin
        check("ack",       64'(mem_wb_ack), 64'(!wb_stall));
        check("rs1_data",  64'(rs1_data),   64'(exp_read(rs1_addr)));
        check("rs2_data",  64'(rs2_data),   64'(exp_read(rs2_addr)));
        check("wb_valid",  64'(wb_valid),   64'(m_valid));
        check("wb_rd",     64'(wb_rd),      64'(m_rd));
        check("wb_data",   64'(wb_data),    64'(m_data));
        check("instret",   instret,         m_instret);
        check("instret_s", 64'(instret_s),  64'(m_instret % 16));
        check("rs1_s",     64'(rs1_s),      64'(exp_read(rs1_addr)));
      end
      @(posedge clk);
      if (!rstn) begin
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_valid = 1'b0; m_rd = 5'd0; m_data = 32'd0; m_instret = 64'd0;
      end else begin
        m_valid = mem_wb_rdy && !wb_stall;
        if (m_valid) begin
          if (mem_wb_we && mem_wb_rd != 5'd0) m_regs[mem_wb_rd] = mem_wb_data;
          m_rd      = mem_wb_we ? mem_wb_rd : 5'd0;
          m_data    = mem_wb_data;
          m_instret = m_instret + 64'd1;
        end
      end
    end
  end

  task automatic drive(input logic rdy, input logic we, input logic [4:0] rd,
                       input logic [31:0] data, input logic stall,
                       input logic [4:0] a1, input logic [4:0] a2);
    mem_wb_rdy = rdy; mem_wb_we = we; mem_wb_rd = rd; mem_wb_data = data;
    wb_stall = stall; rs1_addr = a1; rs2_addr = a2;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    // Basic write to x5
    drive(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd5, 5'd5);
    #1 check("t2_ack", 64'(mem_wb_ack), 64'd1);
    next_cycle();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd5, 5'd0);
    #1;
    check("t2_rs1", 64'(rs1_data), 64'hDEADBEEF);
    check("t2_valid", 64'(wb_valid), 64'd1);
    check("t2_rd", 64'(wb_rd), 64'd5);
    check("t2_instret", instret, 64'd1);

    // x0 write discarded, then retire-only transfer
    next_cycle();
    drive(1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd7);
    next_cycle();
    drive(1'b1, 1'b0, 5'd7, 32'h55, 1'b0, 5'd0, 5'd7);
    #1;
    check("t3_x0", 64'(rs1_data), 64'd0);
    check("t3_rd_a", 64'(wb_rd), 64'd0);
    check("t3_instret_a", instret, 64'd2);
    next_cycle();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd7);
    #1;
    check("t3_x7", 64'(rs2_data), 64'd0);
    check("t3_rd_b", 64'(wb_rd), 64'd0);
    check("t3_data_b", 64'(wb_data), 64'h55);
    check("t3_instret_b", instret, 64'd3);

    // Stall holds everything for three cycles
    next_cycle();
    drive(1'b1, 1'b1, 5'd3, 32'hA5, 1'b1, 5'd3, 5'd3);
    for (int i = 0; i < 3; i++) begin
      #1 check("t4_ack", 64'(mem_wb_ack), 64'd0);
      next_cycle();
      #1;
      check("t4_valid", 64'(wb_valid), 64'd0);
      check("t4_instret", instret, 64'd3);
      check("t4_x3", 64'(rs1_data), 64'd0);
    end
    wb_stall = 1'b0;
    next_cycle();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd3, 5'd0);
    #1;
    check("t4_release_instret", instret, 64'd4);
    check("t4_release_x3", 64'(rs1_data), 64'hA5);

    // Same-cycle read of the committing register
    next_cycle();
    drive(1'b1, 1'b1, 5'd9, 32'h11, 1'b0, 5'd0, 5'd0);
    next_cycle();
    drive(1'b1, 1'b1, 5'd9, 32'h22, 1'b0, 5'd9, 5'd9);
    #1;
    check("t5_rs1_same", 64'(rs1_data), BYPASS ? 64'h22 : 64'h11);
    check("t5_rs2_same", 64'(rs2_data), BYPASS ? 64'h22 : 64'h11);
    next_cycle();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd9, 5'd9);
    #1;
    check("t5_rs1_after", 64'(rs1_data), 64'h22);
    check("t5_instret", instret, 64'd6);

    // Asynchronous reset mid-cycle, with a transfer in flight
    next_cycle();
    drive(1'b1, 1'b1, 5'd5, 32'h1234, 1'b0, 5'd5, 5'd5);
    next_cycle();
    drive(1'b1, 1'b1, 5'd6, 32'h777, 1'b0, 5'd5, 5'd5);
    #1;
    check("t1_pre_x5", 64'(rs1_data), 64'h1234);
    check("t1_pre_instret", instret, 64'd7);
    check("t1_pre_valid", 64'(wb_valid), 64'd1);
    rstn = 1'b0;
    #1;
    check("t1_x5", 64'(rs1_data), 64'd0);
    check("t1_instret", instret, 64'd0);
    check("t1_valid", 64'(wb_valid), 64'd0);
    check("t1_instret_s", 64'(instret_s), 64'd0);
    next_cycle();
    rstn = 1'b1;
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd6, 5'd5);
    #1;
    check("t1_dropped_x6", 64'(rs1_data), 64'd0);
    check("t1_after_instret", instret, 64'd0);

    // Randomized traffic; the 4-bit counter instance wraps many times
    for (int n = 0; n < 3000; n++) begin
      next_cycle();
      mem_wb_rdy  = ($urandom_range(0, 9) < 7);
      wb_stall    = ($urandom_range(0, 3) == 0);
      mem_wb_we   = ($urandom_range(0, 4) != 0);
      mem_wb_rd   = 5'($urandom_range(0, 31));
      mem_wb_data = $urandom;
      rs1_addr    = $urandom_range(0, 1) ? mem_wb_rd : 5'($urandom_range(0, 31));
      rs2_addr    = $urandom_range(0, 2) == 0 ? mem_wb_rd : 5'($urandom_range(0, 31));
    end
    next_cycle();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    repeat (2) next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
